// File: rtl/receiver_datapath.sv
// Receiver datapath: start-bit timing, LSB-first frame deserialisation with parity check,
// and assembly of received characters into fixed-length strings for the display logic.
module receiver_datapath #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STRING_LEN   = 4,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                            clk_2,
    input  logic                            reset,
    input  logic                            rxd,
    input  logic                            PossibleStart,
    input  logic                            WriteChar,
    input  logic                            WriteString,
    output logic                            check,
    output logic                            CharReady,
    output logic                            parity,
    output logic                            StringReady,
    output logic [DATA_BITS-1:0]            char_out,
    output logic [STRING_LEN*DATA_BITS-1:0] string_out,
    output logic                            string_err
);

    localparam int unsigned HALF       = CLKS_PER_BIT / 2;
    localparam int unsigned TMR_W      = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W      = $clog2(DATA_BITS + 2);
    localparam int unsigned PTR_W      = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
    localparam int unsigned FRAME_BITS = DATA_BITS + 1;
    localparam int unsigned STR_W      = STRING_LEN * DATA_BITS;

    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF - 1);
    localparam logic [TMR_W-1:0] HALF_PRE  = TMR_W'(HALF - 2);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_BITS);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(STRING_LEN - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    logic [TMR_W-1:0]      half_cnt_q;
    logic                  check_q;
    logic [TMR_W-1:0]      bit_tmr_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    logic                  char_ready_q;
    logic [DATA_BITS-1:0]  char_q;
    logic                  parity_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic                  err_acc_q;
    logic [STR_W-1:0]      char_buf_q;
    logic [STR_W-1:0]      char_buf_d;
    logic [STR_W-1:0]      string_q;
    logic                  string_err_q;
    logic                  last_slot;

    // Start qualification: count to mid start bit, pulse once, then hold until PossibleStart drops.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            half_cnt_q <= '0;
            check_q    <= 1'b0;
        end else if (!PossibleStart) begin
            half_cnt_q <= '0;
            check_q    <= 1'b0;
        end else begin
            check_q <= 1'b0;
            if (half_cnt_q != HALF_LAST) begin
                half_cnt_q <= half_cnt_q + TMR_W'(1);
                check_q    <= (half_cnt_q == HALF_PRE);
            end
        end
    end

    // New bits enter at the top so the first (LSB) bit ends up at index 0.
    always_comb begin
        shift_d = {rxd, shift_q[FRAME_BITS-1:1]};
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            bit_tmr_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            char_ready_q <= 1'b0;
            char_q       <= '0;
            parity_q     <= 1'b0;
        end else if (!WriteChar) begin
            bit_tmr_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            char_ready_q <= 1'b0;
        end else if (!char_ready_q) begin
            if (bit_tmr_q == TMR_LAST) begin
                bit_tmr_q <= '0;
                shift_q   <= shift_d;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_LAST) begin
                    char_ready_q <= 1'b1;
                    char_q       <= shift_d[DATA_BITS-1:0];
                    parity_q     <= (^shift_d) ^ ODD;
                end
            end else begin
                bit_tmr_q <= bit_tmr_q + TMR_W'(1);
            end
        end
    end

    assign last_slot = (wr_ptr_q == PTR_LAST);

    always_comb begin
        char_buf_d = char_buf_q;
        char_buf_d[wr_ptr_q*DATA_BITS +: DATA_BITS] = char_q;
    end

    // Parity-failed characters are still stored; the error is reported per string.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            err_acc_q    <= 1'b0;
            char_buf_q   <= '0;
            string_q     <= '0;
            string_err_q <= 1'b0;
        end else if (WriteString) begin
            char_buf_q <= char_buf_d;
            if (last_slot) begin
                string_q     <= char_buf_d;
                string_err_q <= err_acc_q | parity_q;
                wr_ptr_q     <= '0;
                err_acc_q    <= 1'b0;
            end else begin
                wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                err_acc_q <= err_acc_q | parity_q;
            end
        end
    end

    assign check       = check_q;
    assign CharReady   = char_ready_q;
    assign parity      = parity_q;
    assign StringReady = WriteString & last_slot;
    assign char_out    = char_q;
    assign string_out  = string_q;
    assign string_err  = string_err_q;

endmodule

// File: tb/tb_receiver_datapath.sv
// Scoreboard bench for receiver_datapath: a driver issues FSM-style strobes and serial frames,
// pushing expected events; a monitor pops and compares as the DUT reports them.
module tb_receiver_datapath;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int LEN  = 4;
    localparam int ODD  = 0;
    localparam int HALF = CPB / 2;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic        par;
    } frame_exp_t;

    typedef struct {
        logic        sr;
        logic [31:0] str;
        logic        err;
    } ws_exp_t;

    logic        clk_2 = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        PossibleStart = 1'b0;
    logic        WriteChar = 1'b0;
    logic        WriteString = 1'b0;
    logic        check;
    logic        CharReady;
    logic        parity;
    logic        StringReady;
    logic [7:0]  char_out;
    logic [31:0] string_out;
    logic        string_err;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    int unsigned chk_q[$];
    frame_exp_t  frm_q[$];
    ws_exp_t     ws_q[$];

    // Reference model of what the string logic should hold.
    logic [7:0]  m_str[$];
    logic        m_err = 1'b0;
    logic [7:0]  m_char = 8'h00;
    logic        m_par = 1'b0;

    receiver_datapath #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STRING_LEN  (LEN),
        .PARITY_ODD  (ODD)
    ) dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .rxd          (rxd),
        .PossibleStart(PossibleStart),
        .WriteChar    (WriteChar),
        .WriteString  (WriteString),
        .check        (check),
        .CharReady    (CharReady),
        .parity       (parity),
        .StringReady  (StringReady),
        .char_out     (char_out),
        .string_out   (string_out),
        .string_err   (string_err)
    );

    initial forever #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic       cr_prev = 1'b0;
    logic       rst_prev = 1'b0;
    logic       pend = 1'b0;
    ws_exp_t    pend_e;
    frame_exp_t fe;
    ws_exp_t    we;
    int unsigned ce;

    initial begin
        forever begin
            @(negedge clk_2);
            #4;
            if (rst_prev && !reset)
                chk("reset_outputs", {check, CharReady, parity, StringReady, char_out,
                                      string_out, string_err}, 64'd0);
            if (!reset) begin
                if (pend) begin
                    chk("string_out", string_out, pend_e.str);
                    chk("string_err", string_err, pend_e.err);
                    pend = 1'b0;
                end
                if (check) begin
                    if (chk_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL check_spurious: check=1 at cycle %0d, none expected", cyc);
                    end else begin
                        ce = chk_q.pop_front();
                        chk("check_cycle", cyc, ce);
                    end
                end
                if (CharReady && !cr_prev) begin
                    if (frm_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL charready_spurious: CharReady rose at cycle %0d", cyc);
                    end else begin
                        fe = frm_q.pop_front();
                        chk("charready_cycle", cyc, fe.cyc);
                        chk("char_out", char_out, fe.data);
                        chk("parity", parity, fe.par);
                    end
                end
                if (WriteString) begin
                    if (ws_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL writestring_unexpected: at cycle %0d", cyc);
                    end else begin
                        we = ws_q.pop_front();
                        chk("StringReady", StringReady, we.sr);
                        if (we.sr) begin
                            pend   = 1'b1;
                            pend_e = we;
                        end
                    end
                end else begin
                    chk("StringReady_idle", StringReady, 1'b0);
                end
            end
            cr_prev  = CharReady;
            rst_prev = reset;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk_2);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        PossibleStart = 1'b0;
        WriteChar     = 1'b0;
        WriteString   = 1'b0;
        rxd           = 1'b1;
        m_str.delete();
        m_err  = 1'b0;
        m_char = 8'h00;
        m_par  = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
        tick();
    endtask

    // PossibleStart held for n sampled edges, then dropped for one cycle.
    task automatic qualify(input int n);
        if (n >= HALF - 1) chk_q.push_back(cyc + HALF - 1);
        PossibleStart = 1'b1;
        repeat (n) tick();
        PossibleStart = 1'b0;
        tick();
    endtask

    // Sends nbits of {pb, d} LSB-first; a full frame (9 bits) is expected to complete.
    task automatic frame(input logic [7:0] d, input logic pb, input int nbits, input int extra);
        logic [8:0] bits;
        logic       good_pb;
        frame_exp_t e;
        bits    = {pb, d};
        good_pb = (^d) ^ (ODD != 0);
        if (nbits == 9) begin
            e.cyc  = cyc + 9 * CPB;
            e.data = d;
            e.par  = (pb != good_pb);
            frm_q.push_back(e);
            m_char = d;
            m_par  = e.par;
        end
        WriteChar = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            rxd = bits[k];
            repeat (CPB) tick();
        end
        rxd = 1'b1;
        repeat (extra) tick();
        if (nbits == 9) begin
            WriteChar = 1'b0;
            tick();
        end
    endtask

    task automatic ws();
        ws_exp_t e;
        m_str.push_back(m_char);
        m_err = m_err | m_par;
        e.sr  = (m_str.size() == LEN);
        e.str = '0;
        e.err = m_err;
        if (e.sr) begin
            for (int i = 0; i < LEN; i++) e.str[i*8 +: 8] = m_str[i];
            m_str.delete();
            m_err = 1'b0;
        end
        ws_q.push_back(e);
        WriteString = 1'b1;
        tick();
        WriteString = 1'b0;
        tick();
    endtask

    task automatic good_char(input logic [7:0] d);
        qualify(HALF);
        frame(d, (^d) ^ (ODD != 0), 9, 1);
        ws();
    endtask

    logic [7:0] rd;
    logic       rpb;

    initial begin
        do_reset(3);

        qualify(5);
        qualify(9);

        frame(8'h41, 1'b0, 9, 2);

        qualify(HALF - 1);
        frame(8'h41, 1'b1, 9, 0);
        ws();
        good_char(8'h42);
        good_char(8'h43);
        good_char(8'h44);

        good_char(8'h48);
        good_char(8'h4F);
        good_char(8'h4C);
        good_char(8'h41);

        good_char(8'h31);
        good_char(8'h32);
        qualify(HALF);
        frame(8'h77, 1'b1, 5, 0);
        do_reset(3);
        qualify(HALF);
        frame(8'h55, 1'b0, 9, 0);
        ws();
        good_char(8'h56);
        good_char(8'h57);
        good_char(8'h58);

        for (int i = 0; i < 16; i++) begin
            qualify($urandom_range(1, 12));
            rd  = 8'($urandom);
            rpb = (^rd) ^ (ODD != 0) ^ ($urandom_range(0, 3) == 0);
            frame(rd, rpb, 9, $urandom_range(0, 2));
            ws();
        end

        repeat (5) tick();
        chk("leftover_check_events", chk_q.size(), 0);
        chk("leftover_frame_events", frm_q.size(), 0);
        chk("leftover_write_events", ws_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
